noc_bus_stop: RTL and testbench

//  Ring stop between the NOC ring and one core's noc_bus_inp_* / noc_bus_oup_* ports.

---
 rtl/noc_bus_stop_pkg.sv | 28 ++
 rtl/noc_bus_stop_if.sv | 15 +
 rtl/noc_bus_stop_skid_fifo.sv | 59 +++++
 rtl/noc_bus_stop.sv | 154 +++++++++++++++
 tb/tb_noc_bus_stop.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_bus_stop_pkg.sv
// Shared types and bit positions for the NOC ring stop.
//   noc_beat_t   : one bus beat, 32 bytes of data plus 6 control bits
//   bp encoding  : [5] valid, [4] last beat of packet, [3:0] destination stop
//   arb_state_t  : states of the ring output arbiter
package noc_bus_stop_pkg;

    localparam int BP_W       = 6;
    localparam int BP_VALID   = 5;
    localparam int BP_LAST    = 4;
    localparam int BP_DEST_HI = 3;
    localparam int BP_DEST_LO = 0;

    typedef struct packed {
        logic [31:0][7:0]  dat;
        logic [BP_W-1:0]   bp;
    } noc_beat_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_THRU  = 2'd1,
        ARB_LOCAL = 2'd2
    } arb_state_t;

    function automatic logic [3:0] beat_dest(input noc_beat_t b);
        return b.bp[BP_DEST_HI:BP_DEST_LO];
    endfunction

endpackage

// File: rtl/noc_bus_stop_if.sv
// One direction of a NOC bus link.
//   dat : 32-byte beat payload        (sender -> receiver)
//   bp  : valid/last/dest control     (sender -> receiver)
//   bo  : backpressure, 1 = stall     (receiver -> sender)
interface noc_bus_stop_if;
    import noc_bus_stop_pkg::*;

    logic [31:0][7:0] dat;
    logic [BP_W-1:0]  bp;
    logic             bo;

    modport master (output dat, output bp, input bo);
    modport slave  (input dat, input bp, output bo);

endinterface

// File: rtl/noc_bus_stop_skid_fifo.sv
// Input skid FIFO for one NOC link.
//   fclk, rst  : clock, asynchronous active-low reset
//   inp        : incoming link (slave side); inp.bo is driven from here
//   head_o     : beat at the FIFO head, meaningful while head_vld_o=1
//   head_vld_o : FIFO holds at least one beat
//   pop_i      : consume the head beat (only asserted while head_vld_o=1)
module noc_bus_stop_skid_fifo
    import noc_bus_stop_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          fclk,
    input  logic          rst,
    noc_bus_stop_if.slave inp,
    output noc_beat_t     head_o,
    output logic          head_vld_o,
    input  logic          pop_i
);
    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    noc_beat_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          bo_q;
    logic          push;

    // The sender sees bo_q, so a beat is taken exactly when it is not stalled.
    assign push    = inp.bp[BP_VALID] && !bo_q;
    assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop_i);

    // bo is held high during reset and derived from the next-state count,
    // so it drops on the first clock after release and never lags a pop.
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bo_q     <= 1'b1;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            bo_q    <= (count_d == FULL_CNT);
        end
    end

    // Storage needs no reset: it is only read once count_q says it was written.
    always_ff @(posedge fclk) begin
        if (push) mem_q[wr_ptr_q] <= '{dat: inp.dat, bp: inp.bp};
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign head_vld_o = (count_q != '0);
    assign inp.bo     = bo_q;

endmodule

// File: rtl/noc_bus_stop.sv
// Ring stop joining the NOC ring to one core.
//   fclk, rst : clock, asynchronous active-low reset
//   ring_inp  : upstream ring beats (slave)
//   ring_oup  : downstream ring beats (master), owned by the arbiter
//   loc_inp   : beats injected by the core (slave)
//   loc_oup   : beats ejected to the core (master)
// Ring beats addressed to STOP_ADDR are ejected; the rest pass through.
// Local packets merge onto the ring whole, never interleaved with through
// traffic. After FAIR_LIMIT through packets finish while a local beat waits,
// the local packet wins the next decision.
module noc_bus_stop
    import noc_bus_stop_pkg::*;
#(
    parameter logic [3:0] STOP_ADDR  = 4'd0,
    parameter int         FAIR_LIMIT = 4,
    parameter int         BUF_DEPTH  = 2
) (
    input  logic           fclk,
    input  logic           rst,
    noc_bus_stop_if.slave  ring_inp,
    noc_bus_stop_if.master ring_oup,
    noc_bus_stop_if.slave  loc_inp,
    noc_bus_stop_if.master loc_oup
);
    localparam int          FW       = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

    noc_beat_t     ring_head;
    noc_beat_t     loc_head;
    logic          ring_head_vld;
    logic          loc_head_vld;
    logic          ring_pop;
    logic          loc_pop;
    logic          eject_pop;
    logic          thru_pop;
    logic          ring_is_eject;
    logic          ring_thru_avail;
    logic          rout_ready;
    logic          lout_ready;
    logic          sel_thru;
    logic          sel_loc;

    arb_state_t    state_q, state_d;
    logic [FW-1:0] fair_q, fair_d;
    noc_beat_t     rout_q, rout_d;
    noc_beat_t     lout_q, lout_d;

    noc_bus_stop_skid_fifo #(.DEPTH(BUF_DEPTH)) u_ring_fifo (
        .fclk       (fclk),
        .rst        (rst),
        .inp        (ring_inp),
        .head_o     (ring_head),
        .head_vld_o (ring_head_vld),
        .pop_i      (ring_pop)
    );

    noc_bus_stop_skid_fifo #(.DEPTH(BUF_DEPTH)) u_loc_fifo (
        .fclk       (fclk),
        .rst        (rst),
        .inp        (loc_inp),
        .head_o     (loc_head),
        .head_vld_o (loc_head_vld),
        .pop_i      (loc_pop)
    );

    assign ring_is_eject   = ring_head_vld && (beat_dest(ring_head) == STOP_ADDR);
    assign ring_thru_avail = ring_head_vld && !ring_is_eject;

    // An output register can take a new beat when empty or being drained.
    assign rout_ready = !rout_q.bp[BP_VALID] || !ring_oup.bo;
    assign lout_ready = !lout_q.bp[BP_VALID] || !loc_oup.bo;

    // Eject steering: an eject beat at the ring head waits for loc_oup,
    // blocking everything behind it in the ring FIFO.
    always_comb begin
        lout_d    = lout_q;
        eject_pop = 1'b0;
        if (lout_ready) begin
            lout_d = '0;
            if (ring_is_eject) begin
                lout_d    = ring_head;
                eject_pop = 1'b1;
            end
        end
    end

    // Arbiter: decides only in IDLE, and the first beat of the winner moves
    // in that same cycle. THRU/LOCAL stay locked until the last beat passes.
    always_comb begin
        state_d  = state_q;
        fair_d   = fair_q;
        rout_d   = rout_q;
        thru_pop = 1'b0;
        loc_pop  = 1'b0;
        sel_thru = 1'b0;
        sel_loc  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (ring_thru_avail && !(loc_head_vld && fair_q == FAIR_MAX)) sel_thru = 1'b1;
                else if (loc_head_vld)                                         sel_loc  = 1'b1;
            end
            ARB_THRU:  sel_thru = ring_thru_avail;
            ARB_LOCAL: sel_loc  = loc_head_vld;
            default:   state_d  = ARB_IDLE;
        endcase

        if (rout_ready) begin
            rout_d = '0;
            if (sel_thru) begin
                rout_d   = ring_head;
                thru_pop = 1'b1;
                if (ring_head.bp[BP_LAST]) begin
                    state_d = ARB_IDLE;
                    if (!loc_head_vld)          fair_d = '0;
                    else if (fair_q != FAIR_MAX) fair_d = fair_q + FW'(1);
                end else begin
                    state_d = ARB_THRU;
                end
            end else if (sel_loc) begin
                rout_d  = loc_head;
                loc_pop = 1'b1;
                if (loc_head.bp[BP_LAST]) begin
                    state_d = ARB_IDLE;
                    fair_d  = '0;
                end else begin
                    state_d = ARB_LOCAL;
                end
            end
        end
    end

    assign ring_pop = thru_pop | eject_pop;

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            fair_q  <= '0;
            rout_q  <= '0;
            lout_q  <= '0;
        end else begin
            state_q <= state_d;
            fair_q  <= fair_d;
            rout_q  <= rout_d;
            lout_q  <= lout_d;
        end
    end

    assign ring_oup.dat = rout_q.dat;
    assign ring_oup.bp  = rout_q.bp;
    assign loc_oup.dat  = lout_q.dat;
    assign loc_oup.bp   = lout_q.bp;

endmodule

// File: tb/tb_noc_bus_stop.sv
// Bench for noc_bus_stop: directed scenarios followed by a randomized phase,
// all checked against per-stream scoreboards (through, local-inject, eject).
module tb_noc_bus_stop;
    import noc_bus_stop_pkg::*;

    localparam logic [3:0] STOP     = 4'd0;
    localparam logic [7:0] TAG_THRU = 8'hA1;
    localparam logic [7:0] TAG_LOC  = 8'hB2;

    typedef logic [263:0] cw_t;

    logic fclk = 1'b0;
    logic rst  = 1'b1;

    noc_bus_stop_if ring_inp ();
    noc_bus_stop_if ring_oup ();
    noc_bus_stop_if loc_inp ();
    noc_bus_stop_if loc_oup ();

    noc_bus_stop #(.STOP_ADDR(STOP), .FAIR_LIMIT(4), .BUF_DEPTH(2)) dut (
        .fclk     (fclk),
        .rst      (rst),
        .ring_inp (ring_inp),
        .ring_oup (ring_oup),
        .loc_inp  (loc_inp),
        .loc_oup  (loc_oup)
    );

    always #5 fclk = ~fclk;

    int checks   = 0;
    int failures = 0;

    noc_beat_t ring_tx[$], loc_tx[$];
    noc_beat_t exp_thru[$], exp_loc[$], exp_ej[$];

    int   gap_pct = 0, rstall_pct = 0, lstall_pct = 0;
    bit   rhold = 1'b0;
    bit   ring_take = 1'b0, loc_take = 1'b0;
    int   cyc = 0, lat_in = -1, lat_out = -1;
    int   thru_pkts = 0, thru_before = -1, loc_first = -1, loc_last = -1;
    int   seq = 0;
    logic [7:0] owner = 8'h00;

    task automatic check(input string tag, input cw_t obs, input cw_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int pending();
        return ring_tx.size() + loc_tx.size() + exp_thru.size() + exp_loc.size() + exp_ej.size();
    endfunction

    // Build a packet and file each beat in the scoreboard of the path the
    // rules send it to: ring->own stop ejects, ring->other passes through,
    // anything from the core goes out on the ring (including loopback).
    task automatic add_pkt(input bit from_ring, input logic [3:0] dest, input int len);
        noc_beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 8; k++) b.dat[k*4 +: 4] = $urandom();
            b.dat[0]  = seq[7:0];
            b.dat[31] = from_ring ? TAG_THRU : TAG_LOC;
            b.bp      = {1'b1, (i == len - 1), dest};
            seq++;
            if (from_ring) begin
                ring_tx.push_back(b);
                if (dest == STOP) exp_ej.push_back(b);
                else              exp_thru.push_back(b);
            end else begin
                loc_tx.push_back(b);
                exp_loc.push_back(b);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge fclk);
            n++;
        end
        check(tag, cw_t'(pending()), cw_t'(0));
    endtask

    // Drivers: present the head of each send queue, hold it while stalled.
    always @(posedge fclk) begin
        #1;
        if (ring_take && ring_tx.size() != 0) void'(ring_tx.pop_front());
        if (loc_take && loc_tx.size() != 0)   void'(loc_tx.pop_front());
        if (ring_tx.size() != 0 &&
            ((ring_inp.bp[BP_VALID] && !ring_take) || int'($urandom_range(99)) >= gap_pct)) begin
            ring_inp.dat = ring_tx[0].dat;
            ring_inp.bp  = ring_tx[0].bp;
        end else begin
            ring_inp.dat = '0;
            ring_inp.bp  = '0;
        end
        if (loc_tx.size() != 0 &&
            ((loc_inp.bp[BP_VALID] && !loc_take) || int'($urandom_range(99)) >= gap_pct)) begin
            loc_inp.dat = loc_tx[0].dat;
            loc_inp.bp  = loc_tx[0].bp;
        end else begin
            loc_inp.dat = '0;
            loc_inp.bp  = '0;
        end
        ring_oup.bo = rhold || (int'($urandom_range(99)) < rstall_pct);
        loc_oup.bo  = (int'($urandom_range(99)) < lstall_pct);
    end

    // Monitor: sample mid-cycle, score every completed output transfer.
    always @(negedge fclk) begin
        noc_beat_t ob, ex;
        cyc++;
        ring_take = ring_inp.bp[BP_VALID] && !ring_inp.bo;
        loc_take  = loc_inp.bp[BP_VALID] && !loc_inp.bo;
        if (ring_take && lat_in < 0) lat_in = cyc;
        if (ring_oup.bp[BP_VALID] && lat_out < 0) lat_out = cyc;
        if (ring_oup.bp[BP_VALID] && !ring_oup.bo) begin
            ob.dat = ring_oup.dat;
            ob.bp  = ring_oup.bp;
            ex     = '0;
            if (owner != 8'h00) check("ring_contig", cw_t'(ob.dat[31]), cw_t'(owner));
            if (ob.dat[31] == TAG_LOC) begin
                if (exp_loc.size() != 0) ex = exp_loc.pop_front();
                if (loc_first < 0) begin
                    loc_first   = cyc;
                    thru_before = thru_pkts;
                end
                loc_last = cyc;
            end else begin
                if (exp_thru.size() != 0) ex = exp_thru.pop_front();
                if (ob.bp[BP_LAST]) thru_pkts++;
            end
            check("ring_oup_beat", cw_t'(ob), cw_t'(ex));
            owner = ob.bp[BP_LAST] ? 8'h00 : ob.dat[31];
        end
        if (loc_oup.bp[BP_VALID] && !loc_oup.bo) begin
            ob.dat = loc_oup.dat;
            ob.bp  = loc_oup.bp;
            ex     = '0;
            if (exp_ej.size() != 0) ex = exp_ej.pop_front();
            check("loc_oup_beat", cw_t'(ob), cw_t'(ex));
        end
    end

    initial begin
        int n;
        ring_inp.dat = '0; ring_inp.bp = '0;
        loc_inp.dat  = '0; loc_inp.bp  = '0;
        ring_oup.bo  = 1'b0; loc_oup.bo = 1'b0;

        // Reset state and release timing
        #3 rst = 1'b0;
        repeat (3) @(posedge fclk);
        #1;
        check("rst_ring_inp_bo", cw_t'(ring_inp.bo), cw_t'(1));
        check("rst_loc_inp_bo",  cw_t'(loc_inp.bo),  cw_t'(1));
        check("rst_ring_oup_bp", cw_t'(ring_oup.bp), cw_t'(0));
        check("rst_loc_oup_bp",  cw_t'(loc_oup.bp),  cw_t'(0));
        check("rst_ring_oup_dat", cw_t'(ring_oup.dat), cw_t'(0));
        check("rst_loc_oup_dat",  cw_t'(loc_oup.dat),  cw_t'(0));
        @(negedge fclk);
        rst = 1'b1;
        #1;
        check("bo_before_clk", cw_t'(ring_inp.bo), cw_t'(1));
        @(posedge fclk);
        #1;
        check("ring_bo_released", cw_t'(ring_inp.bo), cw_t'(0));
        check("loc_bo_released",  cw_t'(loc_inp.bo),  cw_t'(0));
        repeat (4) @(posedge fclk);

        // Eject of a 3-beat packet addressed here
        @(negedge fclk);
        add_pkt(1'b1, STOP, 3);
        drain("eject_3beat", 100);

        // Pass-through 2-beat packet and its latency
        @(negedge fclk);
        lat_in = -1; lat_out = -1;
        add_pkt(1'b1, 4'd5, 2);
        drain("thru_2beat", 100);
        check("thru_latency", cw_t'(lat_out - lat_in), cw_t'(2));

        // Fairness: continuous 1-beat through traffic versus a 2-beat local packet
        @(negedge fclk);
        thru_pkts = 0; thru_before = -1; loc_first = -1; loc_last = -1;
        repeat (10) add_pkt(1'b1, 4'd5, 1);
        add_pkt(1'b0, 4'd7, 2);
        drain("fair_drain", 200);
        check("fair_grant_after", cw_t'(thru_before), cw_t'(4));
        check("local_beats_adjacent", cw_t'(loc_last - loc_first), cw_t'(1));

        // Downstream stall mid-packet
        @(negedge fclk);
        add_pkt(1'b1, 4'd9, 6);
        repeat (4) @(posedge fclk);
        rhold = 1'b1;
        repeat (10) @(posedge fclk);
        @(negedge fclk);
        check("stall_ring_inp_bo", cw_t'(ring_inp.bo), cw_t'(1));
        check("stall_out_held", cw_t'(ring_oup.bp[BP_VALID]), cw_t'(1));
        rhold = 1'b0;
        drain("stall_drain", 200);

        // Reset during beat 2 of a 4-beat local packet
        @(negedge fclk);
        add_pkt(1'b0, 4'd3, 4);
        n = 0;
        while (exp_loc.size() > 3 && n < 50) begin
            @(negedge fclk);
            #1;
            n++;
        end
        check("rst_pkt_beat1_out", cw_t'(exp_loc.size()), cw_t'(3));
        @(posedge fclk);
        #2;
        check("beat2_on_ring", cw_t'(ring_oup.bp[BP_VALID]), cw_t'(1));
        rst = 1'b0;
        #1;
        check("async_rst_ring_bp",  cw_t'(ring_oup.bp),  cw_t'(0));
        check("async_rst_ring_dat", cw_t'(ring_oup.dat), cw_t'(0));
        check("async_rst_loc_bo",   cw_t'(loc_inp.bo),   cw_t'(1));
        loc_tx.delete();
        exp_loc.delete();
        loc_inp.bp  = '0;
        loc_inp.dat = '0;
        owner       = 8'h00;
        repeat (2) @(negedge fclk);
        rst = 1'b1;
        repeat (10) @(posedge fclk);
        #1;
        check("post_rst_ring_bo", cw_t'(ring_inp.bo), cw_t'(0));
        check("post_rst_loc_bo",  cw_t'(loc_inp.bo),  cw_t'(0));
        @(negedge fclk);
        lat_in = -1; lat_out = -1;
        add_pkt(1'b1, 4'd5, 1);
        drain("post_rst_thru", 100);
        check("post_rst_latency", cw_t'(lat_out - lat_in), cw_t'(2));

        // Loopback: local packet addressed to this stop still goes out on the ring
        @(negedge fclk);
        add_pkt(1'b0, STOP, 2);
        drain("loopback", 100);

        // Randomized mix with input gaps and output stalls
        gap_pct = 20; rstall_pct = 30; lstall_pct = 30;
        @(negedge fclk);
        repeat (80) begin
            add_pkt($urandom_range(1) == 1,
                    ($urandom_range(2) == 0) ? STOP : 4'($urandom_range(15)),
                    int'($urandom_range(4, 1)));
        end
        drain("random_drain", 8000);
        gap_pct = 0; rstall_pct = 0; lstall_pct = 0;
        repeat (20) @(posedge fclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
